// File: rtl/mem_sram_bridge_if.sv
// Request/response channel bundle between a bus requester and mem_sram_bridge.
// The requester holds the master modport; the bridge holds the slave modport.
interface mem_sram_bridge_if #(
  parameter int AW    = 32,
  parameter int WIDTH = 64
);
  logic               req_req;
  logic               req_gnt;
  logic               req_wen;
  logic [WIDTH/8-1:0] req_strb;
  logic [AW-1:0]      req_addr;
  logic [WIDTH-1:0]   req_wdata;

  logic               rsp_recv;
  logic               rsp_ack;
  logic [WIDTH-1:0]   rsp_rdata;
  logic               rsp_error;

  modport master (
    output req_req, req_wen, req_strb, req_addr, req_wdata, rsp_ack,
    input  req_gnt, rsp_recv, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_req, req_wen, req_strb, req_addr, req_wdata, rsp_ack,
    output req_gnt, rsp_recv, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mem_sram_bridge.sv
// Bridges a req/gnt + recv/ack bus onto a single-port SRAM with 1-cycle registered
// read data; responses stall into hold registers when the requester back-pressures.
module mem_sram_bridge #(
  parameter int            AW    = 32,
  parameter int            WIDTH = 64,
  parameter int            DEPTH = 1024,
  parameter logic [AW-1:0] BASE  = 'h2000_0000
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  mem_sram_bridge_if.slave         bus,
  output logic                     mem_cen,
  output logic [WIDTH/8-1:0]       mem_wstrb,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  input  logic                     mem_err
);

  localparam int BW   = $clog2(WIDTH / 8);
  localparam int DW   = $clog2(DEPTH);
  localparam int OFFW = BW + DW;

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

  state_t           state;
  logic             wen_q;
  logic             inr_q;
  logic [WIDTH-1:0] hold_rdata;
  logic             hold_error;

  logic             accept;
  logic             in_range;
  logic [WIDTH-1:0] live_rdata;
  logic             live_error;
  logic             unused_addr_bits;

  assign in_range = (bus.req_addr[AW-1:OFFW] == BASE[AW-1:OFFW]);

  // Grant is combinational so a response can be acked and a new request taken in one cycle.
  assign bus.req_gnt = g_resetn && ((state == IDLE) || bus.rsp_ack);
  assign accept      = bus.req_req && bus.req_gnt;

  assign mem_cen   = accept && in_range;
  assign mem_wstrb = (mem_cen && bus.req_wen) ? bus.req_strb : '0;
  assign mem_addr  = bus.req_addr[BW +: DW];
  assign mem_wdata = bus.req_wdata;

  // Byte lane offset within a word carries no information for a word-wide SRAM.
  assign unused_addr_bits = ^bus.req_addr[BW-1:0];

  assign live_rdata = (inr_q && !wen_q) ? mem_rdata : '0;
  assign live_error = inr_q ? mem_err : 1'b1;

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    bus.rsp_recv  = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_error = 1'b0;
    if (g_resetn) begin
      case (state)
        RESP: begin
          bus.rsp_recv  = 1'b1;
          bus.rsp_rdata = live_rdata;
          bus.rsp_error = live_error;
        end
        HOLD: begin
          bus.rsp_recv  = 1'b1;
          bus.rsp_rdata = hold_rdata;
          bus.rsp_error = hold_error;
        end
        default: ;
      endcase
    end
  end

  // NOTE: reset is sampled on the clock edge; state uses non-blocking assignments only.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state      <= IDLE;
      wen_q      <= 1'b0;
      inr_q      <= 1'b0;
      hold_rdata <= '0;
      hold_error <= 1'b0;
    end else if (accept) begin
      state <= RESP;
      wen_q <= bus.req_wen;
      inr_q <= in_range;
    end else begin
      case (state)
        RESP: begin
          if (bus.rsp_ack) begin
            state <= IDLE;
          end else begin
            // SRAM data is only valid for one cycle, so freeze it before it moves on.
            state      <= HOLD;
            hold_rdata <= live_rdata;
            hold_error <= live_error;
          end
        end
        HOLD: if (bus.rsp_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
